// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_share_arbiter                                                |
// | Brief   : Round-robin sharing of one ALU datapath between two requesters.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_share_arbiter #(
  parameter int EXEC_CYCLES = 1,
  parameter int WIDTH       = 32
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             req0Valid,
  output logic             req0Ready,
  input  logic [1:0]       req0AluOp,
  input  logic [31:0]      req0Instruction,
  input  logic [WIDTH-1:0] req0OperandA,
  input  logic [WIDTH-1:0] req0OperandB,
  input  logic             req1Valid,
  output logic             req1Ready,
  input  logic [1:0]       req1AluOp,
  input  logic [31:0]      req1Instruction,
  input  logic [WIDTH-1:0] req1OperandA,
  input  logic [WIDTH-1:0] req1OperandB,
  output logic             resp0Valid,
  output logic             resp1Valid,
  input  logic             resp0Ready,
  input  logic             resp1Ready,
  output logic [WIDTH-1:0] respResult,
  output logic             respOverflow,
  output logic [1:0]       dpAluOp,
  output logic [31:0]      dpInstruction,
  output logic [WIDTH-1:0] dpMuxOutA,
  output logic [WIDTH-1:0] dpMuxOutB,
  input  logic [WIDTH-1:0] dpAluOut,
  input  logic             dpOverflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] C_CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t           state_q,    state_d;
  logic             rr_ptr_q,   rr_ptr_d;
  logic             grant_q,    grant_d;
  logic [3:0]       cnt_q,      cnt_d;
  logic [1:0]       alu_op_q,   alu_op_d;
  logic [31:0]      instr_q,    instr_d;
  logic [WIDTH-1:0] opa_q,      opa_d;
  logic [WIDTH-1:0] opb_q,      opb_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             ovf_q,      ovf_d;

  logic w_any_req;
  logic w_win_id;
  logic w_accept;
  logic w_resp_taken;

  // rr_ptr_q names the requester that wins a tie: the one not granted last.
  assign w_any_req    = req0Valid | req1Valid;
  assign w_win_id     = (req0Valid & req1Valid) ? rr_ptr_q : req1Valid;
  assign req0Ready    = (state_q == IDLE) & w_any_req & ~w_win_id;
  assign req1Ready    = (state_q == IDLE) & w_any_req & w_win_id;
  assign w_accept     = req0Ready | req1Ready;
  assign w_resp_taken = grant_q ? resp1Ready : resp0Ready;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    alu_op_d = alu_op_q;
    instr_d  = instr_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          alu_op_d = w_win_id ? req1AluOp       : req0AluOp;
          instr_d  = w_win_id ? req1Instruction : req0Instruction;
          opa_d    = w_win_id ? req1OperandA    : req0OperandA;
          opb_d    = w_win_id ? req1OperandB    : req0OperandB;
          grant_d  = w_win_id;
          rr_ptr_d = ~w_win_id;
          cnt_d    = C_CNT_LOAD;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d = dpAluOut;
          ovf_d    = dpOverflow;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (w_resp_taken) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      grant_q  <= 1'b0;
      cnt_q    <= 4'd0;
      alu_op_q <= 2'd0;
      instr_q  <= 32'd0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      alu_op_q <= alu_op_d;
      instr_q  <= instr_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign resp0Valid    = (state_q == RESP) & ~grant_q;
  assign resp1Valid    = (state_q == RESP) & grant_q;
  assign respResult    = result_q;
  assign respOverflow  = ovf_q;
  assign dpAluOp       = alu_op_q;
  assign dpInstruction = instr_q;
  assign dpMuxOutA     = opa_q;
  assign dpMuxOutB     = opb_q;
  assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_share_arbiter                                             |
// | Brief   : Directed scoreboard bench for alu_share_arbiter.                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_alu_share_arbiter;

  localparam int          W      = 32;
  localparam logic [31:0] C_ADD  = 32'h0000_0020;
  localparam logic [31:0] C_KEY  = 32'hA500_0000;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] cyc = 32'd0;
  always @(posedge clock) cyc <= cyc + 32'd1;

  logic         req0Valid = 0, req1Valid = 0, resp0Ready = 1, resp1Ready = 1;
  logic [1:0]   req0AluOp = 0, req1AluOp = 0;
  logic [31:0]  req0Instruction = 0, req1Instruction = 0;
  logic [W-1:0] req0OperandA = 0, req0OperandB = 0, req1OperandA = 0, req1OperandB = 0;
  logic         req0Ready, req1Ready, resp0Valid, resp1Valid, respOverflow, busy, dpOverflow;
  logic [W-1:0] respResult, dpMuxOutA, dpMuxOutB, dpAluOut;
  logic [1:0]   dpAluOp;
  logic [31:0]  dpInstruction;

  function automatic logic [32:0] exp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    return {(a[31] == b[31]) && (s[31] != a[31]), s};
  endfunction

  // Bench-side ALU standing in for the datapath.
  always_comb {dpOverflow, dpAluOut} = exp_add(dpMuxOutA, dpMuxOutB);

  alu_share_arbiter #(.EXEC_CYCLES(1), .WIDTH(W)) u_dut (
    .clock(clock), .resetN(resetN),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0AluOp(req0AluOp),
    .req0Instruction(req0Instruction), .req0OperandA(req0OperandA), .req0OperandB(req0OperandB),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1AluOp(req1AluOp),
    .req1Instruction(req1Instruction), .req1OperandA(req1OperandA), .req1OperandB(req1OperandB),
    .resp0Valid(resp0Valid), .resp1Valid(resp1Valid), .resp0Ready(resp0Ready), .resp1Ready(resp1Ready),
    .respResult(respResult), .respOverflow(respOverflow),
    .dpAluOp(dpAluOp), .dpInstruction(dpInstruction), .dpMuxOutA(dpMuxOutA), .dpMuxOutB(dpMuxOutB),
    .dpAluOut(dpAluOut), .dpOverflow(dpOverflow), .busy(busy)
  );

  // Second instance with a 3-cycle execute; its datapath output tracks the cycle count.
  logic         x_req0Valid = 0;
  logic         x_req0Ready, x_req1Ready, x_resp0Valid, x_resp1Valid, x_respOverflow, x_busy;
  logic [W-1:0] x_respResult, x_dpMuxOutA, x_dpMuxOutB;
  logic [1:0]   x_dpAluOp;
  logic [31:0]  x_dpInstruction;
  logic [W-1:0] x_dpAluOut;
  logic         x_dpOverflow;
  assign x_dpAluOut   = cyc ^ C_KEY;
  assign x_dpOverflow = cyc[0];

  alu_share_arbiter #(.EXEC_CYCLES(3), .WIDTH(W)) u_dut3 (
    .clock(clock), .resetN(resetN),
    .req0Valid(x_req0Valid), .req0Ready(x_req0Ready), .req0AluOp(2'b10),
    .req0Instruction(C_ADD), .req0OperandA(32'h11), .req0OperandB(32'h22),
    .req1Valid(1'b0), .req1Ready(x_req1Ready), .req1AluOp(2'b00),
    .req1Instruction(32'd0), .req1OperandA(32'd0), .req1OperandB(32'd0),
    .resp0Valid(x_resp0Valid), .resp1Valid(x_resp1Valid), .resp0Ready(1'b1), .resp1Ready(1'b1),
    .respResult(x_respResult), .respOverflow(x_respOverflow),
    .dpAluOp(x_dpAluOp), .dpInstruction(x_dpInstruction), .dpMuxOutA(x_dpMuxOutA), .dpMuxOutB(x_dpMuxOutB),
    .dpAluOut(x_dpAluOut), .dpOverflow(x_dpOverflow), .busy(x_busy)
  );

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic rr_pref  = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with requester fields driven; returns at the
  // negedge after the response handshake.
  task automatic run_txn(input bit drop, input int hold);
    logic         w;
    int           lat;
    logic [31:0]  t;
    logic [97:0]  exp_dp;
    exp_t         e;
    w = (req0Valid && req1Valid) ? rr_pref : req1Valid;
    #1;
    lat = 0;
    while (!(req0Ready || req1Ready) && lat < 20) begin
      @(negedge clock); #1; lat++;
    end
    check("accept_seen", {127'd0, req0Ready | req1Ready}, 128'd1);
    check("grant", {126'd0, req1Ready, req0Ready}, w ? 128'd2 : 128'd1);
    e.id = w;
    {e.ovf, e.res} = w ? exp_add(req1OperandA, req1OperandB) : exp_add(req0OperandA, req0OperandB);
    sb.push_back(e);
    exp_dp = w ? {req1AluOp, req1Instruction, req1OperandA, req1OperandB}
               : {req0AluOp, req0Instruction, req0OperandA, req0OperandB};
    rr_pref = ~w;
    t = cyc;
    @(negedge clock);
    check("exec_busy_ready", {125'd0, busy, req1Ready, req0Ready}, 128'd4);
    check("exec_dp", {30'd0, dpAluOp, dpInstruction, dpMuxOutA, dpMuxOutB}, {30'd0, exp_dp});
    if (drop) begin
      if (w) req1Valid = 1'b0; else req0Valid = 1'b0;
    end
    lat = 0;
    while (!(resp0Valid || resp1Valid) && lat < 40) begin
      @(negedge clock); lat++;
    end
    check("resp_latency", {96'd0, cyc - t}, 128'd2);
    e = sb.pop_front();
    check("resp_id", {126'd0, resp1Valid, resp0Valid}, e.id ? 128'd2 : 128'd1);
    check("resp_data", {95'd0, respOverflow, respResult}, {95'd0, e.ovf, e.res});
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_stable", {92'd0, resp1Valid, resp0Valid, busy, req1Ready, req0Ready, respResult},
            {92'd0, e.id, ~e.id, 1'b1, 2'b00, e.res});
    end
    if (hold > 0) begin
      if (w) resp1Ready = 1'b1; else resp0Ready = 1'b1;
    end
    @(negedge clock);
    check("resp_one_cycle", {125'd0, resp1Valid, resp0Valid, busy}, 128'd0);
  endtask

  initial begin
    logic [31:0] t3;
    int          lat;
    #1;
    check("rst_flags", {122'd0, busy, resp0Valid, resp1Valid, respOverflow, req0Ready, req1Ready}, 128'd0);
    check("rst_dp", {30'd0, dpAluOp, dpInstruction, dpMuxOutA, dpMuxOutB}, 128'd0);
    check("rst_result", {96'd0, respResult}, 128'd0);
    @(negedge clock); @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);

    // Single request, 5+7.
    req0AluOp = 2'b10; req0Instruction = C_ADD; req0OperandA = 32'd5; req0OperandB = 32'd7;
    req0Valid = 1'b1;
    run_txn(1'b1, 0);

    // Overflow passthrough on requester 1.
    req1AluOp = 2'b10; req1Instruction = C_ADD; req1OperandA = 32'h7FFF_FFFF; req1OperandB = 32'd1;
    req1Valid = 1'b1;
    run_txn(1'b1, 0);

    // Reset in the middle of EXEC discards the transaction.
    req0OperandA = 32'd100; req0OperandB = 32'd1;
    req0Valid = 1'b1;
    #1;
    check("mid_accept", {126'd0, req1Ready, req0Ready}, 128'd1);
    @(negedge clock);
    req0Valid = 1'b0;
    check("mid_busy", {127'd0, busy}, 128'd1);
    resetN = 1'b0;
    #1;
    check("mid_rst_flags", {124'd0, busy, resp0Valid, resp1Valid, respOverflow}, 128'd0);
    check("mid_rst_dp", {30'd0, dpAluOp, dpInstruction, dpMuxOutA, dpMuxOutB, respResult} >> 32, 128'd0);
    check("mid_rst_result", {96'd0, respResult}, 128'd0);
    @(negedge clock);
    resetN  = 1'b1;
    rr_pref = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("mid_no_resp", {125'd0, resp1Valid, resp0Valid, busy}, 128'd0);
    end

    // Continuous contention: 0,1,0,1.
    req0OperandA = 32'd10; req0OperandB = 32'd1;
    req1OperandA = 32'd20; req1OperandB = 32'd2;
    req0Valid = 1'b1; req1Valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_txn(1'b0, 0);
      req0OperandA = req0OperandA + 32'd1;
      req1OperandA = req1OperandA + 32'd1;
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
    @(negedge clock);

    // Requester 1 streaming alone still moves the pointer.
    req1Valid = 1'b1; req1OperandA = 32'hFFFF_FFFF; req1OperandB = 32'hFFFF_FFFF;
    run_txn(1'b0, 0);
    run_txn(1'b1, 0);

    // Backpressure: requester 0 wins the tie, holds its response for 5 cycles.
    req0OperandA = 32'h8000_0000; req0OperandB = 32'h8000_0000;
    req1OperandA = 32'd3; req1OperandB = 32'd4;
    req0Valid = 1'b1; req1Valid = 1'b1;
    resp0Ready = 1'b0;
    run_txn(1'b1, 5);
    #1;
    check("bp_accept_next", {126'd0, req1Ready, req0Ready}, 128'd2);
    run_txn(1'b1, 0);

    // EXEC_CYCLES=3 instance.
    x_req0Valid = 1'b1;
    #1;
    lat = 0;
    while (!x_req0Ready && lat < 20) begin
      @(negedge clock); #1; lat++;
    end
    check("x3_accept", {127'd0, x_req0Ready}, 128'd1);
    t3 = cyc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      x_req0Valid = 1'b0;
      check("x3_exec", {28'd0, x_busy, x_resp0Valid, x_dpAluOp, x_dpInstruction, x_dpMuxOutA, x_dpMuxOutB},
            {28'd0, 1'b1, 1'b0, 2'b10, C_ADD, 32'h11, 32'h22});
    end
    @(negedge clock);
    check("x3_resp_at_t4", {96'd0, cyc - t3}, 128'd4);
    t3 = t3 + 32'd3;
    check("x3_resp", {94'd0, x_resp1Valid, x_resp0Valid, x_respOverflow, x_respResult},
          {94'd0, 1'b0, 1'b1, t3[0], t3 ^ C_KEY});
    @(negedge clock);
    check("x3_done", {126'd0, x_resp0Valid, x_busy}, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single ALU datapath (ALU control decode + 32-bit ALU) between two requesters using round-robin arbitration.
- Each transaction follows the same sequence: latch one request, drive the datapath for a fixed number of execution cycles, capture the result and overflow, then return them to the granted requester over a valid/ready response handshake.
- Sits between the two issuing units and the datapath's aluOp/instruction/operand inputs.

Parameters:
- EXEC_CYCLES, 1, number of cycles the datapath inputs are held before aluOut/overflow are sampled (legal range 1..15).
- WIDTH, 32, operand/result width.

Ports:
- clock  in  1  system clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- req0Valid  in  1  requester 0 has a request.
- req0Ready  out  1  requester 0 request accepted this cycle.
- req0AluOp  in  2  requester 0 aluOp.
- req0Instruction  in  32  requester 0 instruction word.
- req0OperandA / req0OperandB  in  WIDTH  requester 0 operands.
- req1Valid, req1Ready, req1AluOp, req1Instruction, req1OperandA, req1OperandB: same as requester 0, for requester 1.
- resp0Valid  out  1  response pending for requester 0.
- resp1Valid  out  1  response pending for requester 1.
- resp0Ready / resp1Ready  in  1  requester takes the response.
- respResult  out  WIDTH  shared response data.
- respOverflow  out  1  shared response overflow flag.
- dpAluOp  out  2  to datapath aluOp.
- dpInstruction  out  32  to datapath instruction.
- dpMuxOutA / dpMuxOutB  out  WIDTH  to datapath operands.
- dpAluOut  in  WIDTH  datapath result.
- dpOverflow  in  1  datapath overflow.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- Reset (resetN low, asynchronous):
  - state=IDLE.
  - All outputs 0, including dp* registers, respResult and respOverflow.
  - Round-robin pointer favours requester 0.
  - Exec counter = 0.
- States: IDLE, EXEC, RESP.
- IDLE, arbitration and accept:
  - reqNReady is combinational and asserted only for the arbitration winner, only while in IDLE.
  - Winner rules: if only one reqNValid is high, that requester wins. If both are high, the requester not granted last wins.
  - On accept (valid && ready): latch aluOp, instruction and operands into the dp* output registers; record grant id; update pointer; load counter with EXEC_CYCLES-1; go to EXEC.
  - No request: stay in IDLE; dp* registers hold their last values.
- EXEC:
  - dp* outputs held stable.
  - If counter != 0, decrement.
  - If counter == 0: capture dpAluOut into respResult and dpOverflow into respOverflow; go to RESP.
- RESP:
  - Only the granted respNValid is high; the other stays 0.
  - respResult and respOverflow held stable.
  - When the granted respNReady is high: go to IDLE. respNValid deasserts the next cycle.
  - The non-granted respNReady is ignored.
- Latency: request accepted in cycle T; respNValid first high in cycle T+EXEC_CYCLES+1.
- Throughput: one transaction per EXEC_CYCLES+2 cycles minimum, because a new accept is possible only in the cycle after the RESP handshake completes.
- Boundaries:
  - Requests arriving while busy are not accepted. reqNReady stays 0 and the requester must hold its valid and fields.
  - Simultaneous requests on the first arbitration after reset: requester 0 wins.
  - Back-to-back simultaneous requests alternate 0,1,0,1.
  - Single-requester stream: that requester wins every time; the pointer still updates.
  - resetN asserted mid-EXEC or mid-RESP: the transaction is discarded, no response is produced, and the state returns to IDLE.
  - respNReady held high permanently: RESP lasts exactly one cycle.
- No arithmetic is performed in this block. Overflow is passed through unmodified.

Test Plan:
- Reset mid-flow: assert resetN=0 during EXEC -> all outputs 0 immediately; after release, state IDLE; a fresh request proceeds normally with no stale response.
- Single request: req0 with aluOp=2'b10, funct=0x20 (add), A=5, B=7, EXEC_CYCLES=1, datapath returns 12 -> req0Ready high 1 cycle; resp0Valid high at T+2; respResult=12, respOverflow=0; resp1Valid stays 0.
- Overflow passthrough: req1 with add, A=0x7FFFFFFF, B=1 -> respResult=0x80000000, respOverflow=1 on resp1Valid.
- Contention: both valid continuously for 4 transactions -> grants in order 0,1,0,1; a non-granted ready is never high.
- Backpressure: hold resp0Ready=0 for 5 cycles -> resp0Valid and respResult stable; req1 not accepted; busy=1 throughout; accept occurs the cycle after resp0Ready is asserted.
- EXEC_CYCLES=3: dp* outputs stable for 3 cycles; the capture uses dpAluOut from the third EXEC cycle; resp valid at T+4.
